// File: rtl/test_status_reporter_if.sv
`timescale 1ns/1ps
// test_status_reporter_if: tohost handshake between the SoC (master) and the
// test status reporter (slave).
//   tohost_valid  SoC offers a tohost word
//   tohost_data   bit0 = exit flag, bits[31:1] = exit code
//   tohost_ready  reporter accepts; a transfer happens when valid and ready
//                 are both high on a rising clock edge
interface test_status_reporter_if;
  localparam int unsigned DATA_W = 32;

  logic              tohost_valid;
  logic [DATA_W-1:0] tohost_data;
  logic              tohost_ready;

  modport master (
    output tohost_valid,
    output tohost_data,
    input  tohost_ready
  );

  modport slave (
    input  tohost_valid,
    input  tohost_data,
    output tohost_ready
  );
endinterface

// File: rtl/test_status_reporter.sv
`timescale 1ns/1ps
// test_status_reporter: generates a stretched SoC reset from the board reset
// pin, then watches the tohost channel for the test exit word and reports
// pass/fail/timeout on sticky status outputs.
//   clock        single clock, all state on its rising edge
//   reset        board reset pin, asynchronous, active low
//   tohost       slave side of the tohost handshake (valid/data/ready)
//   sys_reset    active-high SoC reset, async assert, sync deassert
//   io_success   test passed (sticky)
//   io_fail      test failed or timed out (sticky)
//   io_done      io_success | io_fail
//   exit_code    captured exit code, all-ones after timeout
//   cycle_count  cycles spent in RUN
module test_status_reporter #(
  parameter int unsigned RST_STRETCH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clock,
  input  logic                         reset,
  test_status_reporter_if.slave        tohost,
  output logic                         sys_reset,
  output logic                         io_success,
  output logic                         io_fail,
  output logic                         io_done,
  output logic [30:0]                  exit_code,
  output logic [31:0]                  cycle_count
);

  localparam int unsigned STRETCH_W = 8;
  localparam int unsigned CODE_W    = 31;
  localparam int unsigned COUNT_W   = 32;

  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RST_STRETCH - 1);
  localparam logic [COUNT_W-1:0]   TIMEOUT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  logic [1:0]           sync_q;
  logic                 rst_released;
  state_t               state_q;
  state_t               state_next;
  logic [STRETCH_W-1:0] stretch_q;
  logic                 xfer_c;
  logic                 exit_c;
  logic                 timeout_c;
  logic [CODE_W-1:0]    code_c;

  // Two-flop synchronizer for reset release; assertion clears it at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_released = sync_q[1];

  // Transfer qualification; ready is already a RUN decode, state check is belt and braces.
  assign xfer_c    = tohost.tohost_valid && tohost.tohost_ready && (state_q == S_RUN);
  assign exit_c    = xfer_c && tohost.tohost_data[0];
  assign code_c    = tohost.tohost_data[31:1];
  assign timeout_c = (cycle_count == TIMEOUT_LAST);

  // Next-state decode; an exit transfer takes priority over the timeout.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_HOLD: begin
        if (rst_released && (stretch_q == STRETCH_LAST)) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (exit_c) begin
          state_next = (code_c == '0) ? S_PASS : S_FAIL;
        end else if (timeout_c) begin
          state_next = S_TIMEOUT;
        end
      end
      default: state_next = state_q;
    endcase
  end

  // State, counters and registered status outputs (decoded from next state).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q             <= S_HOLD;
      stretch_q           <= '0;
      cycle_count         <= '0;
      exit_code           <= '0;
      sys_reset           <= 1'b1;
      tohost.tohost_ready <= 1'b0;
      io_success          <= 1'b0;
      io_fail             <= 1'b0;
      io_done             <= 1'b0;
    end else begin
      state_q <= state_next;

      if ((state_q == S_HOLD) && rst_released) begin
        stretch_q <= stretch_q + 1'b1;
      end

      if (state_q == S_RUN) begin
        cycle_count <= cycle_count + 1'b1;
        if (exit_c) begin
          exit_code <= code_c;
        end else if (timeout_c) begin
          exit_code <= '1;
        end
      end

      sys_reset           <= (state_next == S_HOLD);
      tohost.tohost_ready <= (state_next == S_RUN);
      io_success          <= (state_next == S_PASS);
      io_fail             <= (state_next == S_FAIL) || (state_next == S_TIMEOUT);
      io_done             <= (state_next == S_PASS) || (state_next == S_FAIL) ||
                             (state_next == S_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_test_status_reporter.sv
`timescale 1ns/1ps
// tb_test_status_reporter: randomized self-checking bench for
// test_status_reporter against a cycle-level behavioural model.
module tb_test_status_reporter;

  localparam int unsigned RST_STRETCH    = 16;
  localparam int unsigned TIMEOUT_CYCLES = 100;
  localparam int          HOLD_EDGES     = 2 + RST_STRETCH;
  localparam int          OC_RUN  = 0;
  localparam int          OC_PASS = 1;
  localparam int          OC_FAIL = 2;
  localparam int          OC_TMO  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sys_reset;
  logic        io_success;
  logic        io_fail;
  logic        io_done;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;
  logic [4:0]  act_flags;

  test_status_reporter_if tif();

  test_status_reporter #(
    .RST_STRETCH   (RST_STRETCH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tohost     (tif.slave),
    .sys_reset  (sys_reset),
    .io_success (io_success),
    .io_fail    (io_fail),
    .io_done    (io_done),
    .exit_code  (exit_code),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  assign act_flags = {sys_reset, tif.tohost_ready, io_success, io_fail, io_done};

  int errors = 0;
  int checks = 0;
  int dut_xfers = 0;

  // Model: edges since reset release, test outcome, RUN cycles, exit code.
  int          m_edges;
  int          m_outcome;
  int          m_accepts;
  logic [31:0] m_count;
  logic [30:0] m_code;

  // Observed handshake transfers on the DUT side.
  always @(posedge clock) begin
    if (reset && tif.tohost_valid && tif.tohost_ready) dut_xfers++;
  end

  function automatic logic [4:0] exp_flags();
    logic sr;
    logic rd;
    sr = (m_edges < HOLD_EDGES);
    rd = !sr && (m_outcome == OC_RUN);
    return {sr, rd, m_outcome == OC_PASS,
            (m_outcome == OC_FAIL) || (m_outcome == OC_TMO),
            m_outcome != OC_RUN};
  endfunction

  task automatic model_clear();
    m_edges   = 0;
    m_outcome = OC_RUN;
    m_accepts = 0;
    m_count   = '0;
    m_code    = '0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge.
  task automatic step();
    logic        v;
    logic [31:0] d;
    logic        running;
    v       = tif.tohost_valid;
    d       = tif.tohost_data;
    running = (m_edges >= HOLD_EDGES) && (m_outcome == OC_RUN);
    @(posedge clock);
    if (running) begin
      if (v) begin
        m_accepts++;
        if (d[0]) begin
          m_code    = d[31:1];
          m_outcome = (d[31:1] == 31'd0) ? OC_PASS : OC_FAIL;
        end
      end
      if ((m_outcome == OC_RUN) && (m_count == 32'(TIMEOUT_CYCLES - 1))) begin
        m_outcome = OC_TMO;
        m_code    = 31'h7FFF_FFFF;
      end
      m_count++;
    end
    if (m_edges < HOLD_EDGES) m_edges++;
    #1;
  endtask

  // Pulse reset, release it between edges and run through HOLD.
  task automatic start_run(input logic v, input logic [31:0] d);
    tif.tohost_valid = v;
    tif.tohost_data  = d;
    reset = 1'b0;
    model_clear();
    #2;
    reset = 1'b1;
    for (int i = 0; i < HOLD_EDGES; i++) step();
  endtask

  task automatic test_reset();
    tif.tohost_valid = 1'b0;
    tif.tohost_data  = '0;
    model_clear();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (act_flags !== 5'b10000) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", act_flags, 5'b10000);
    end
    checks++;
    if (exit_code !== 31'd0) begin
      errors++; $display("FAIL reset_exit_code: got %h expected 0", exit_code);
    end
    checks++;
    if (cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count);
    end
    #1 reset = 1'b1;
    for (int i = 1; i <= HOLD_EDGES + 3; i++) begin
      step();
      checks++;
      if (sys_reset !== 1'(i < HOLD_EDGES)) begin
        errors++; $display("FAIL release_sys_reset edge %0d: got %b expected %b", i, sys_reset, i < HOLD_EDGES);
      end
      checks++;
      if (act_flags !== exp_flags()) begin
        errors++; $display("FAIL release_flags edge %0d: got %b expected %b", i, act_flags, exp_flags());
      end
    end
    checks++;
    if (cycle_count !== 32'd3) begin
      errors++; $display("FAIL release_cycle_count: got %0d expected 3", cycle_count);
    end
  endtask

  task automatic test_pass();
    int base;
    start_run(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tif.tohost_valid = 1'($urandom_range(0, 1));
      tif.tohost_data  = $urandom() & 32'hFFFF_FFFE;
      step();
      checks++;
      if (act_flags !== exp_flags() || cycle_count !== m_count) begin
        errors++; $display("FAIL pass_noise: flags %b count %0d expected %b %0d", act_flags, cycle_count, exp_flags(), m_count);
      end
    end
    tif.tohost_valid = 1'b1;
    tif.tohost_data  = 32'h0000_0001;
    step();
    checks++;
    if ({io_success, io_fail, io_done, exit_code} !== {3'b101, 31'd0}) begin
      errors++; $display("FAIL pass_status: got s=%b f=%b d=%b code=%h expected 1 0 1 0", io_success, io_fail, io_done, exit_code);
    end
    base = dut_xfers;
    for (int i = 0; i < 10; i++) begin
      tif.tohost_data = $urandom();
      step();
      checks++;
      if (act_flags !== exp_flags() || cycle_count !== m_count || exit_code !== 31'd0) begin
        errors++; $display("FAIL pass_sticky: flags %b count %0d code %h expected %b %0d 0", act_flags, cycle_count, exit_code, exp_flags(), m_count);
      end
    end
    checks++;
    if (dut_xfers !== base) begin
      errors++; $display("FAIL pass_ignored_xfers: got %0d expected %0d", dut_xfers, base);
    end
    tif.tohost_valid = 1'b0;
  endtask

  task automatic test_fail();
    int base;
    start_run(1'b0, 32'h0);
    step();
    base = dut_xfers;
    tif.tohost_valid = 1'b1;
    tif.tohost_data  = 32'h0000_0002;
    step();
    checks++;
    if (dut_xfers !== base + 1 || act_flags !== 5'b01000) begin
      errors++; $display("FAIL nonexit_word: xfers %0d flags %b expected %0d 01000", dut_xfers, act_flags, base + 1);
    end
    tif.tohost_data = 32'h0000_0007;
    step();
    tif.tohost_valid = 1'b0;
    checks++;
    if ({io_success, io_fail, io_done, exit_code} !== {3'b011, 31'd3}) begin
      errors++; $display("FAIL fail_status: got s=%b f=%b d=%b code=%h expected 0 1 1 3", io_success, io_fail, io_done, exit_code);
    end
    checks++;
    if (cycle_count !== m_count) begin
      errors++; $display("FAIL fail_count: got %0d expected %0d", cycle_count, m_count);
    end
  endtask

  task automatic test_random_exit();
    logic [30:0] code;
    int          idle;
    for (int t = 0; t < 6; t++) begin
      start_run(1'b0, 32'h0);
      idle = $urandom_range(0, 30);
      for (int i = 0; i < idle; i++) begin
        tif.tohost_valid = 1'($urandom_range(0, 1));
        tif.tohost_data  = $urandom() & 32'hFFFF_FFFE;
        step();
      end
      code = ($urandom_range(0, 2) == 0) ? 31'd0 : 31'($urandom());
      tif.tohost_valid = 1'b1;
      tif.tohost_data  = {code, 1'b1};
      step();
      tif.tohost_valid = 1'b0;
      step();
      checks++;
      if (act_flags !== exp_flags() || exit_code !== m_code || cycle_count !== m_count) begin
        errors++; $display("FAIL random_exit %0d: flags %b code %h count %0d expected %b %h %0d", t, act_flags, exit_code, cycle_count, exp_flags(), m_code, m_count);
      end
    end
  endtask

  task automatic test_timeout();
    start_run(1'b0, 32'h0);
    for (int i = 0; i < int'(TIMEOUT_CYCLES) + 5; i++) begin
      step();
      checks++;
      if (act_flags !== exp_flags() || cycle_count !== m_count) begin
        errors++; $display("FAIL timeout_walk %0d: flags %b count %0d expected %b %0d", i, act_flags, cycle_count, exp_flags(), m_count);
      end
    end
    checks++;
    if ({io_success, io_fail, io_done} !== 3'b011 || exit_code !== 31'h7FFF_FFFF) begin
      errors++; $display("FAIL timeout_status: s=%b f=%b d=%b code=%h expected 0 1 1 7fffffff", io_success, io_fail, io_done, exit_code);
    end
    checks++;
    if (cycle_count !== 32'(TIMEOUT_CYCLES)) begin
      errors++; $display("FAIL timeout_frozen_count: got %0d expected %0d", cycle_count, TIMEOUT_CYCLES);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (act_flags !== 5'b10000 || exit_code !== 31'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL terminal_reset: flags %b code %h count %0d expected 10000 0 0", act_flags, exit_code, cycle_count);
    end
  endtask

  task automatic test_exit_at_last();
    logic [30:0] code;
    for (int t = 0; t < 2; t++) begin
      code = (t == 0) ? 31'd0 : 31'd5;
      start_run(1'b0, 32'h0);
      for (int i = 0; i < int'(TIMEOUT_CYCLES) - 1; i++) step();
      checks++;
      if (cycle_count !== 32'(TIMEOUT_CYCLES - 1) || tif.tohost_ready !== 1'b1) begin
        errors++; $display("FAIL exit_last_setup: count %0d ready %b expected %0d 1", cycle_count, tif.tohost_ready, TIMEOUT_CYCLES - 1);
      end
      tif.tohost_valid = 1'b1;
      tif.tohost_data  = {code, 1'b1};
      step();
      tif.tohost_valid = 1'b0;
      checks++;
      if ({io_success, io_fail} !== ((t == 0) ? 2'b10 : 2'b01) || exit_code !== code) begin
        errors++; $display("FAIL exit_beats_timeout %0d: s=%b f=%b code=%h expected code %h", t, io_success, io_fail, exit_code, code);
      end
      checks++;
      if (act_flags !== exp_flags() || cycle_count !== m_count) begin
        errors++; $display("FAIL exit_last_model %0d: flags %b count %0d expected %b %0d", t, act_flags, cycle_count, exp_flags(), m_count);
      end
    end
  endtask

  task automatic test_async_reset();
    start_run(1'b0, 32'h0);
    for (int i = 0; i < 50; i++) step();
    checks++;
    if (cycle_count !== 32'd50) begin
      errors++; $display("FAIL midrun_count: got %0d expected 50", cycle_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (act_flags !== 5'b10000 || exit_code !== 31'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL midrun_async_reset: flags %b code %h count %0d expected 10000 0 0", act_flags, exit_code, cycle_count);
    end
    reset = 1'b1;
    model_clear();
    for (int i = 1; i <= HOLD_EDGES + 2; i++) begin
      step();
      checks++;
      if (sys_reset !== 1'(i < HOLD_EDGES) || act_flags !== exp_flags()) begin
        errors++; $display("FAIL rehold edge %0d: flags %b expected %b", i, act_flags, exp_flags());
      end
    end
  endtask

  task automatic test_hold_valid();
    int base;
    base = dut_xfers;
    start_run(1'b1, 32'h0000_0001);
    checks++;
    if (dut_xfers !== base || tif.tohost_ready !== 1'b1) begin
      errors++; $display("FAIL hold_no_xfer: xfers %0d ready %b expected %0d 1", dut_xfers, tif.tohost_ready, base);
    end
    for (int i = 0; i < 5; i++) step();
    tif.tohost_valid = 1'b0;
    checks++;
    if (dut_xfers !== base + 1) begin
      errors++; $display("FAIL hold_one_xfer: got %0d expected %0d", dut_xfers, base + 1);
    end
    checks++;
    if (io_success !== 1'b1 || cycle_count !== 32'd1 || m_accepts != 1) begin
      errors++; $display("FAIL hold_first_run_xfer: s=%b count %0d expected 1 1", io_success, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_random_exit();
    test_timeout();
    test_exit_at_last();
    test_async_reset();
    test_hold_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/test_status_reporter.md
TEST_STATUS_REPORTER -- requirements
Module: test_status_reporter

Interface
REQ-001 Parameter RST_STRETCH, default 16: cycles sys_reset stays high after synchronized reset release; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: run-phase cycle budget before timeout; legal range 2..2^32-1.
REQ-003 clock  input  1  single clock; all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low board reset pin; low = reset.
REQ-005 sys_reset  output  1  active-high reset to the SoC; assertion is asynchronous, deassertion is synchronous.
REQ-006 tohost_valid  input  1  SoC offers a tohost word.
REQ-007 tohost_data  input  32  tohost word; bit0 = exit flag, bits[31:1] = exit code.
REQ-008 tohost_ready  output  1  reporter accepts the word; transfer when valid and ready are both high on a clock edge.
REQ-009 io_success  output  1  test passed; sticky.
REQ-010 io_fail  output  1  test failed or timed out; sticky.
REQ-011 io_done  output  1  io_success OR io_fail.
REQ-012 exit_code  output  31  captured exit code; all-ones after timeout.
REQ-013 cycle_count  output  32  cycles spent in RUN.

Function
REQ-014 Release of reset is synchronized by a 2-flop synchronizer; assertion of reset clears all state immediately, without needing a clock.
REQ-015 FSM states: HOLD, RUN, PASS, FAIL, TIMEOUT; reset enters HOLD.
REQ-016 HOLD: a stretch counter starts when the synchronized reset is released; after exactly RST_STRETCH cycles the FSM moves to RUN.
REQ-017 sys_reset is 1 in HOLD and 0 in every other state.
REQ-018 tohost_ready is 1 only in RUN; it is a registered state decode with no combinational path from tohost_valid.
REQ-019 In RUN, a transfer with tohost_data[0]=0 is accepted and discarded; no state change.
REQ-020 In RUN, a transfer with tohost_data[0]=1 captures exit_code = tohost_data[31:1] in the same cycle, then moves to PASS if the code is 0, else to FAIL.
REQ-021 cycle_count increments by 1 on every RUN cycle, starting from 0 on RUN entry, and freezes on leaving RUN.
REQ-022 On the RUN cycle where cycle_count equals TIMEOUT_CYCLES-1 with no exit transfer, the FSM moves to TIMEOUT and exit_code becomes 31'h7FFFFFFF.
REQ-023 If an exit transfer and the timeout condition occur in the same cycle, the exit transfer wins.
REQ-024 io_success = 1 in PASS only; io_fail = 1 in FAIL and TIMEOUT; all status outputs are registered and change one cycle after the deciding edge.
REQ-025 PASS, FAIL and TIMEOUT are terminal; they hold until reset, and tohost_valid is ignored in them.
REQ-026 tohost_valid in HOLD is not accepted; the word is not lost, because the SoC must hold it until ready.

Reset
REQ-027 While reset is low: sys_reset=1, tohost_ready=0, io_success=0, io_fail=0, io_done=0, exit_code=0, cycle_count=0, FSM=HOLD, stretch counter=0.
REQ-028 Reset asserted mid-RUN or in a terminal state takes effect asynchronously and restarts the full HOLD sequence on release.
REQ-029 A reset pulse shorter than one clock period still clears all state.

Verification
REQ-030 With RST_STRETCH=16, release reset -> sys_reset falls exactly 2+16 clocks after release, and tohost_ready rises on the same cycle.
REQ-031 In RUN, send tohost_data=32'h0000_0001 -> io_success=1, io_done=1, exit_code=0 one cycle after the transfer; subsequent valid words are ignored.
REQ-032 Send tohost_data=32'h0000_0002 (non-exit), then 32'h0000_0007 -> first word is accepted with no change; second gives io_fail=1, exit_code=3.
REQ-033 With TIMEOUT_CYCLES=100 and no exit -> io_fail=1, exit_code=31'h7FFFFFFF, cycle_count frozen at 100; also check an exit transfer on cycle 99 -> PASS/FAIL from the exit word, not TIMEOUT.
REQ-034 Assert reset for 1 ns mid-RUN with cycle_count=50 -> all outputs return to reset values immediately; HOLD repeats on release.
REQ-035 Hold tohost_valid=1 during HOLD -> no transfer until the first RUN cycle, then exactly one transfer is accepted.
